// File: rtl/r5fp_pkg.sv
// Shared definitions for the R5FP adder retire path: adder status bit
// positions, RISC-V fflags bit positions, status-to-fflags conversion and
// the canonical NaN pattern generator.
package r5fp_pkg;

    // Adder status bit indices
    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_INVALID = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    // RISC-V fflags bit positions: {NV,DZ,OF,UF,NX}
    localparam int FF_NX    = 0;
    localparam int FF_UF    = 1;
    localparam int FF_OF    = 2;
    localparam int FF_DZ    = 3;
    localparam int FF_NV    = 4;
    localparam int FFLAGS_W = 5;

    // Widest result format canon_nan can describe
    localparam int CANON_MAX_W = 64;

    // Adder status to fflags. An adder never divides, so DZ is always 0.
    // Underflow is only reported when the tiny result was also inexact.
    function automatic logic [FFLAGS_W-1:0] status_to_fflags(input logic [7:0] status);
        logic [FFLAGS_W-1:0] ff;
        logic                unused_bits;
        unused_bits = ^{status[7:6], status[ST_INF], status[ST_ZERO]};
        ff          = '0;
        ff[FF_NV]   = status[ST_INVALID];
        ff[FF_DZ]   = 1'b0;
        ff[FF_OF]   = status[ST_HUGE];
        ff[FF_UF]   = status[ST_TINY] & status[ST_INEXACT];
        ff[FF_NX]   = status[ST_INEXACT];
        return ff;
    endfunction

    // Canonical quiet NaN {0, exp all-ones, sig MSB set, rest 0}, right-aligned
    // in a CANON_MAX_W vector; callers keep the low EXP_W+SIG_W+1 bits.
    function automatic logic [CANON_MAX_W-1:0] canon_nan(input int exp_w, input int sig_w);
        logic [CANON_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < CANON_MAX_W; i++) begin
            if ((i == sig_w - 1) || ((i >= sig_w) && (i < sig_w + exp_w))) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/r5fp_sync_fifo.sv
// Generic DEPTH x WIDTH in-order register queue with read/write pointers,
// occupancy count and a synchronous flush. DEPTH must be a power of two so
// the pointers wrap naturally. Storage is cleared by reset so the head reads
// zero before anything is written.
module r5fp_sync_fifo
    import r5fp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state: write slot, pointer advance and count; flush wins over push
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Queue state registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/r5fp_add_retire.sv
// Retire stage after the R5FP adder. Converts adder status to RISC-V fflags
// at push time, queues {tag, fflags, result} in order, presents the head to
// the consumer and accrues retired flags into the sticky fflags register.
// Optional feature: define R5FP_CANON_NAN_EN to replace any NaN result with
// the canonical NaN on push; otherwise results are stored bit-exact.
module r5fp_add_retire
    import r5fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int SIG_W = 10,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+SIG_W:0]   in_z,
    input  logic [7:0]             in_status,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+SIG_W:0]   out_z,
    output logic [FFLAGS_W-1:0]    out_fflags,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   flush,
    input  logic                   fflags_wr,
    input  logic                   fflags_clr,
    input  logic [FFLAGS_W-1:0]    fflags_wdata,
    output logic [FFLAGS_W-1:0]    fflags
);

    localparam int Z_W   = EXP_W + SIG_W + 1;
    localparam int ENT_W = TAG_W + FFLAGS_W + Z_W;

    localparam logic [CANON_MAX_W-1:0] CANON_FULL = canon_nan(EXP_W, SIG_W);
    localparam logic [Z_W-1:0]         CANON_Z    = CANON_FULL[Z_W-1:0];

    logic [Z_W-1:0]      store_z;
    logic [ENT_W-1:0]    wr_entry;
    logic [ENT_W-1:0]    head_entry;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_fire;
    logic [FFLAGS_W-1:0] retired_ff;
    logic [FFLAGS_W-1:0] fflags_q, fflags_d;

    // Result value as stored: optionally canonicalize NaNs
    always_comb begin
        store_z = in_z;
`ifdef R5FP_CANON_NAN_EN
        if ((&in_z[Z_W-2 -: EXP_W]) && (|in_z[SIG_W-1:0])) begin
            store_z = CANON_Z;
        end
`endif
    end

    assign wr_entry = {in_tag, status_to_fflags(in_status), store_z};

    r5fp_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .flush   (flush),
        .wr_en   (in_valid),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .rd_en   (out_ready),
        .rd_data (head_entry),
        .empty   (fifo_empty)
    );

    // Ready depends only on occupancy, never on out_ready
    assign in_ready   = ~fifo_full;
    assign out_valid  = ~fifo_empty;
    assign out_z      = head_entry[Z_W-1:0];
    assign out_fflags = head_entry[Z_W +: FFLAGS_W];
    assign out_tag    = head_entry[Z_W+FFLAGS_W +: TAG_W];

    assign pop_fire   = out_valid & out_ready;
    assign retired_ff = pop_fire ? out_fflags : '0;

    // Sticky flags: write beats clear beats accrue; the retiring entry's
    // flags are always merged, even on a flush cycle
    always_comb begin
        fflags_d = fflags_q | retired_ff;
        if (fflags_wr) begin
            fflags_d = fflags_wdata | retired_ff;
        end else if (fflags_clr) begin
            fflags_d = retired_ff;
        end
    end

    // Sticky flags register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

    assign fflags = fflags_q;

endmodule

// File: tb/tb_r5fp_add_retire.sv
// Self-checking bench for r5fp_add_retire: directed scenarios followed by a
// randomized phase, all checked against a queue-based behavioural model.
module tb_r5fp_add_retire;

    localparam int EXP_W = 5;
    localparam int SIG_W = 10;
    localparam int TAG_W = 4;
    localparam int DEPTH = 2;
    localparam int Z_W   = EXP_W + SIG_W + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [Z_W-1:0]   in_z;
    logic [7:0]       in_status;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [Z_W-1:0]   out_z;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
    logic             fflags_wr;
    logic             fflags_clr;
    logic [4:0]       fflags_wdata;
    logic [4:0]       fflags;

    r5fp_add_retire #(
        .EXP_W (EXP_W),
        .SIG_W (SIG_W),
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_status    (in_status),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_fflags   (out_fflags),
        .out_tag      (out_tag),
        .flush        (flush),
        .fflags_wr    (fflags_wr),
        .fflags_clr   (fflags_clr),
        .fflags_wdata (fflags_wdata),
        .fflags       (fflags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [Z_W-1:0]   z;
        logic [4:0]       ff;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t       mq[$];
    logic [4:0] m_sticky;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Flags as the RISC-V rules define them for an add result
    function automatic logic [4:0] model_ff(input logic [7:0] s);
        logic nv, dz, of, uf, nx;
        nv = s[2];
        dz = 1'b0;
        of = s[4];
        nx = s[5];
        uf = s[3] && s[5];
        return {nv, dz, of, uf, nx};
    endfunction

    function automatic logic [Z_W-1:0] model_z(input logic [Z_W-1:0] z);
`ifdef R5FP_CANON_NAN_EN
        if (z[14:10] == 5'h1F && z[9:0] != 10'd0) return 16'h7E00;
`endif
        return z;
    endfunction

    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        check("fflags", 32'(fflags), 32'(m_sticky));
        if (mq.size() != 0) begin
            check("out_z", 32'(out_z), 32'(mq[0].z));
            check("out_fflags", 32'(out_fflags), 32'(mq[0].ff));
            check("out_tag", 32'(out_tag), 32'(mq[0].tag));
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model with the
    // inputs currently driven, then step past the rising edge
    task automatic cycle();
        bit         do_push, do_pop;
        logic [4:0] r;
        ent_t       e;
        @(negedge clk);
        check_outputs();
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() != 0);
        r       = do_pop ? mq[0].ff : 5'd0;
        if (fflags_wr)       m_sticky = fflags_wdata | r;
        else if (fflags_clr) m_sticky = r;
        else                 m_sticky = m_sticky | r;
        e.z   = model_z(in_z);
        e.ff  = model_ff(in_status);
        e.tag = in_tag;
        if (do_pop) void'(mq.pop_front());
        if (flush) mq.delete();
        else if (do_push) mq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [Z_W-1:0] z, input logic [7:0] s,
                         input logic [TAG_W-1:0] t);
        in_valid  = v;
        in_z      = z;
        in_status = s;
        in_tag    = t;
    endtask

    task automatic idle_ctrl();
        flush        = 1'b0;
        fflags_wr    = 1'b0;
        fflags_clr   = 1'b0;
        fflags_wdata = 5'd0;
    endtask

    logic [4:0] seq_exp [3];
    logic [7:0] seq_st  [3];

    initial begin
        reset = 1'b0;
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b0;
        idle_ctrl();
        m_sticky = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_fflags", 32'(fflags), 32'd0);
        check("rst_out_z", 32'(out_z), 32'd0);
        check("rst_out_fflags", 32'(out_fflags), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        reset = 1'b1;
        cycle();

        // Single result, one-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 16'h3C00, 8'h00, 4'd3);
        cycle();
        drive(1'b0, '0, '0, '0);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_z", 32'(out_z), 32'h3C00);
        check("lat_tag", 32'(out_tag), 32'd3);
        check("lat_ff", 32'(out_fflags), 32'd0);
        cycle();
        check("lat_sticky", 32'(fflags), 32'd0);

        // Status conversion sequence
        seq_st[0] = 8'h28; seq_exp[0] = 5'b00011;
        seq_st[1] = 8'h30; seq_exp[1] = 5'b00101;
        seq_st[2] = 8'h04; seq_exp[2] = 5'b10000;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h4000 + 16'(i), seq_st[i], 4'(i + 5));
            cycle();
            check("seq_ff", 32'(out_fflags), 32'(seq_exp[i]));
        end
        drive(1'b0, '0, '0, '0);
        cycle();
        check("seq_sticky", 32'(fflags), 32'b10111);

        // Backpressure: full queue stalls the producer, head holds stable
        out_ready = 1'b0;
        drive(1'b1, 16'h1111, 8'h20, 4'd1);
        cycle();
        check("bp_ready1", 32'(in_ready), 32'd1);
        drive(1'b1, 16'h2222, 8'h10, 4'd2);
        cycle();
        check("bp_ready2", 32'(in_ready), 32'd0);
        drive(1'b1, 16'h3333, 8'h04, 4'd3);
        cycle();
        check("bp_head", 32'(out_z), 32'h1111);
        cycle();
        check("bp_hold", 32'(out_z), 32'h1111);
        out_ready = 1'b1;
        repeat (3) cycle();
        drive(1'b0, '0, '0, '0);
        repeat (2) cycle();

        // Pop with clear, then pop with write
        out_ready = 1'b0;
        drive(1'b1, 16'h5555, 8'h20, 4'd7);
        cycle();
        drive(1'b0, '0, '0, '0);
        out_ready  = 1'b1;
        fflags_clr = 1'b1;
        cycle();
        idle_ctrl();
        check("clr_sticky", 32'(fflags), 32'b00001);
        out_ready = 1'b0;
        drive(1'b1, 16'h6666, 8'h20, 4'd8);
        cycle();
        drive(1'b0, '0, '0, '0);
        out_ready    = 1'b1;
        fflags_clr   = 1'b1;
        fflags_wr    = 1'b1;
        fflags_wdata = 5'b10000;
        cycle();
        idle_ctrl();
        check("wr_sticky", 32'(fflags), 32'b10001);

        // Flush with a concurrent push
        out_ready = 1'b0;
        drive(1'b1, 16'h7001, 8'h30, 4'd9);
        cycle();
        drive(1'b1, 16'h7002, 8'h04, 4'd10);
        cycle();
        drive(1'b1, 16'h7003, 8'h28, 4'd11);
        flush = 1'b1;
        cycle();
        idle_ctrl();
        drive(1'b0, '0, '0, '0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_sticky", 32'(fflags), 32'b10001);
        cycle();

        // Asynchronous reset mid-stream
        drive(1'b1, 16'h1234, 8'h24, 4'd12);
        cycle();
        cycle();
        drive(1'b0, '0, '0, '0);
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_fflags", 32'(fflags), 32'd0);
        check("arst_z", 32'(out_z), 32'd0);
        check("arst_tag", 32'(out_tag), 32'd0);
        mq.delete();
        m_sticky = 5'd0;
        reset = 1'b1;
        cycle();

        // NaN handling
        out_ready = 1'b1;
        drive(1'b1, 16'hFE01, 8'h04, 4'd13);
        cycle();
        drive(1'b0, '0, '0, '0);
`ifdef R5FP_CANON_NAN_EN
        check("nan_z", 32'(out_z), 32'h7E00);
`else
        check("nan_z", 32'(out_z), 32'hFE01);
`endif
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [Z_W-1:0] z;
            z = Z_W'($urandom);
            if ($urandom_range(7) == 0) z[14:10] = 5'h1F;
            drive(1'($urandom_range(3) != 0), z, 8'($urandom), TAG_W'($urandom));
            out_ready    = ($urandom_range(2) != 0);
            flush        = ($urandom_range(31) == 0);
            fflags_wr    = ($urandom_range(31) == 0);
            fflags_clr   = ($urandom_range(31) == 0);
            fflags_wdata = 5'($urandom);
            cycle();
        end
        idle_ctrl();
        drive(1'b0, '0, '0, '0);
        out_ready = 1'b1;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
